// File: rtl/oh_ser2par_rx.sv
// Serial-to-parallel receiver: gathers SW-bit beats into a PW-bit word and
// presents it right-aligned on a valid/wait handshake.
module oh_ser2par_rx #(
  parameter int PW = 64,
  parameter int SW = 1,
  parameter int CW = $clog2(PW / SW) + 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [SW-1:0] din,
  input  logic          access_in,
  input  logic [7:0]    datasize,
  input  logic          lsbfirst,
  output logic [PW-1:0] dout,
  output logic          access_out,
  input  logic          wait_in,
  output logic          wait_out,
  output logic          overflow
);

  localparam int NB = PW / SW;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] len_q, len_d;
  logic          lsb_q, lsb_d;
  logic [PW-1:0] shiftreg_q, shiftreg_d;
  logic [PW-1:0] dout_q, dout_d;
  logic          access_q, access_d;
  logic          overflow_q, overflow_d;

  logic          accept;
  logic          complete;
  logic [CW-1:0] len_new;
  logic [CW-1:0] len_cur;
  logic          lsb_cur;
  logic [PW-1:0] sh_base;
  logic [PW-1:0] sh_next;
  logic [PW-1:0] word;
  int            shamt;

  assign wait_out = access_q & wait_in;
  assign accept   = access_in & ~wait_out;

  // Out-of-range or zero frame sizes fall back to a full word.
  always_comb begin
    if (datasize == 8'd0 || int'(datasize) > NB) begin
      len_new = CW'(NB);
    end else begin
      len_new = CW'(datasize);
    end
  end

  always_comb begin
    len_cur = (state_q == IDLE) ? len_new : len_q;
    lsb_cur = (state_q == IDLE) ? lsbfirst : lsb_q;
    sh_base = (state_q == IDLE) ? '0 : shiftreg_q;
    if (lsb_cur) begin
      sh_next = {din, sh_base[PW-1:SW]};
    end else begin
      sh_next = {sh_base[PW-SW-1:0], din};
    end
    // LSB-first frames shorter than a full word land in the top bits.
    shamt = SW * (NB - int'(len_cur));
    word  = lsb_cur ? (sh_next >> shamt) : sh_next;
  end

  always_comb begin
    complete = 1'b0;
    if (accept) begin
      complete = (state_q == IDLE) ? (len_new == CW'(1)) : (count_q == CW'(1));
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    len_d      = len_q;
    lsb_d      = lsb_q;
    shiftreg_d = shiftreg_q;
    if (accept) begin
      shiftreg_d = sh_next;
      if (state_q == IDLE) begin
        len_d   = len_new;
        lsb_d   = lsbfirst;
        count_d = len_new - CW'(1);
        state_d = (len_new == CW'(1)) ? IDLE : RECV;
      end else begin
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = IDLE;
        end
      end
    end
  end

  always_comb begin
    dout_d     = complete ? word : dout_q;
    access_d   = complete | (access_q & wait_in);
    overflow_d = overflow_q | (access_in & wait_out);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      len_q      <= '0;
      lsb_q      <= 1'b0;
      shiftreg_q <= '0;
      dout_q     <= '0;
      access_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      len_q      <= len_d;
      lsb_q      <= lsb_d;
      shiftreg_q <= shiftreg_d;
      dout_q     <= dout_d;
      access_q   <= access_d;
      overflow_q <= overflow_d;
    end
  end

  assign dout       = dout_q;
  assign access_out = access_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_oh_ser2par_rx.sv
// Directed bench for oh_ser2par_rx: one bit-serial and one byte-serial instance.
module tb_oh_ser2par_rx;

  logic        clk;
  logic        nreset;

  logic        din_a;
  logic        acc_a;
  logic [7:0]  ds_a;
  logic        lsb_a;
  logic        wait_a;
  logic [63:0] dout_a;
  logic        access_out_a;
  logic        wait_out_a;
  logic        overflow_a;

  logic [7:0]  din_b;
  logic        acc_b;
  logic [7:0]  ds_b;
  logic        lsb_b;
  logic        wait_b;
  logic [63:0] dout_b;
  logic        access_out_b;
  logic        wait_out_b;
  logic        overflow_b;

  int checks;
  int failures;

  oh_ser2par_rx #(.PW(64), .SW(1)) u_dut_a (
    .clk        (clk),
    .nreset     (nreset),
    .din        (din_a),
    .access_in  (acc_a),
    .datasize   (ds_a),
    .lsbfirst   (lsb_a),
    .dout       (dout_a),
    .access_out (access_out_a),
    .wait_in    (wait_a),
    .wait_out   (wait_out_a),
    .overflow   (overflow_a)
  );

  oh_ser2par_rx #(.PW(64), .SW(8)) u_dut_b (
    .clk        (clk),
    .nreset     (nreset),
    .din        (din_b),
    .access_in  (acc_b),
    .datasize   (ds_b),
    .lsbfirst   (lsb_b),
    .dout       (dout_b),
    .access_out (access_out_b),
    .wait_in    (wait_b),
    .wait_out   (wait_out_b),
    .overflow   (overflow_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic beat_a(input logic d);
    @(negedge clk);
    din_a = d;
    acc_a = 1'b1;
    @(posedge clk);
    #1;
    acc_a = 1'b0;
  endtask

  task automatic beat_b(input logic [7:0] d);
    @(negedge clk);
    din_b = d;
    acc_b = 1'b1;
    @(posedge clk);
    #1;
    acc_b = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    checks   = 0;
    failures = 0;
    nreset   = 1'b0;
    din_a = 1'b0; acc_a = 1'b0; ds_a = 8'd0; lsb_a = 1'b0; wait_a = 1'b0;
    din_b = 8'd0; acc_b = 1'b0; ds_b = 8'd0; lsb_b = 1'b0; wait_b = 1'b0;
    pat = 8'b1010_0101;

    repeat (2) @(posedge clk);
    #1;
    check("rst_dout_a", dout_a, 64'd0);
    check("rst_access_a", {63'd0, access_out_a}, 64'd0);
    check("rst_wait_out_a", {63'd0, wait_out_a}, 64'd0);
    check("rst_overflow_a", {63'd0, overflow_a}, 64'd0);
    check("rst_dout_b", dout_b, 64'd0);
    @(negedge clk);
    nreset = 1'b1;

    // MSB-first 8-bit frame on the bit-serial instance
    ds_a  = 8'd8;
    lsb_a = 1'b0;
    for (int i = 7; i >= 1; i--) beat_a(pat[i]);
    check("msb8_pre_access", {63'd0, access_out_a}, 64'd0);
    beat_a(pat[0]);
    check("msb8_access", {63'd0, access_out_a}, 64'd1);
    check("msb8_dout", dout_a, 64'h0000_0000_0000_00A5);
    @(posedge clk);
    #1;
    check("msb8_consumed", {63'd0, access_out_a}, 64'd0);

    // LSB-first: same bit sequence, and a short asymmetric frame
    lsb_a = 1'b1;
    for (int i = 7; i >= 0; i--) beat_a(pat[i]);
    check("lsb8_dout", dout_a, 64'h0000_0000_0000_00A5);
    ds_a = 8'd4;
    beat_a(1'b1); beat_a(1'b1); beat_a(1'b0); beat_a(1'b0);
    check("lsb4_dout", dout_a, 64'h0000_0000_0000_0003);
    lsb_a = 1'b0;
    beat_a(1'b1); beat_a(1'b1); beat_a(1'b0); beat_a(1'b0);
    check("msb4_dout", dout_a, 64'h0000_0000_0000_000C);

    // Byte-serial: datasize=0 clamps to 8 beats
    ds_b  = 8'd0;
    lsb_b = 1'b0;
    for (int i = 1; i <= 7; i++) beat_b(8'(i * 17));
    check("ds0_pre_access", {63'd0, access_out_b}, 64'd0);
    beat_b(8'h88);
    check("ds0_access", {63'd0, access_out_b}, 64'd1);
    check("ds0_dout", dout_b, 64'h1122_3344_5566_7788);
    ds_b  = 8'd9;
    lsb_b = 1'b1;
    for (int i = 1; i <= 8; i++) beat_b(8'(i));
    check("ds9_lsb_dout", dout_b, 64'h0807_0605_0403_0201);
    ds_b = 8'd3;
    beat_b(8'hAA); beat_b(8'hBB); beat_b(8'hCC);
    check("lsb3_dout", dout_b, 64'h0000_0000_00CC_BBAA);

    // Stall with a pending word: beats are dropped and flagged
    @(negedge clk);
    wait_a = 1'b1;
    ds_a   = 8'd1;
    lsb_a  = 1'b0;
    beat_a(1'b1);
    check("stall_access", {63'd0, access_out_a}, 64'd1);
    check("stall_dout", dout_a, 64'd1);
    check("stall_wait_out", {63'd0, wait_out_a}, 64'd1);
    check("stall_no_ovf", {63'd0, overflow_a}, 64'd0);
    beat_a(1'b0); beat_a(1'b0); beat_a(1'b0);
    check("stall_ovf", {63'd0, overflow_a}, 64'd1);
    check("stall_dout_hold", dout_a, 64'd1);
    check("stall_access_hold", {63'd0, access_out_a}, 64'd1);
    @(negedge clk);
    wait_a = 1'b0;
    @(posedge clk);
    #1;
    check("release_access", {63'd0, access_out_a}, 64'd0);
    check("release_wait_out", {63'd0, wait_out_a}, 64'd0);
    ds_a = 8'd2;
    beat_a(1'b1); beat_a(1'b0);
    check("after_stall_dout", dout_a, 64'd2);
    check("ovf_sticky", {63'd0, overflow_a}, 64'd1);

    // Back-to-back single-beat frames
    @(negedge clk);
    ds_b  = 8'd1;
    lsb_b = 1'b0;
    din_b = 8'h01;
    acc_b = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      check("b2b_access", {63'd0, access_out_b}, 64'd1);
      check("b2b_dout", dout_b, 64'(i));
      din_b = 8'(i + 1);
    end
    acc_b = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_end_access", {63'd0, access_out_b}, 64'd0);

    // Reset mid-frame discards the partial word
    ds_a  = 8'd8;
    lsb_a = 1'b0;
    for (int i = 0; i < 5; i++) beat_a(1'b1);
    check("mid_no_access", {63'd0, access_out_a}, 64'd0);
    #2;
    nreset = 1'b0;
    #1;
    check("mid_rst_dout", dout_a, 64'd0);
    check("mid_rst_ovf", {63'd0, overflow_a}, 64'd0);
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 4; i++) beat_a(1'b0);
    for (int i = 0; i < 3; i++) beat_a(1'b1);
    check("fresh_pre_access", {63'd0, access_out_a}, 64'd0);
    beat_a(1'b1);
    check("fresh_access", {63'd0, access_out_a}, 64'd1);
    check("fresh_dout", dout_a, 64'h0000_0000_0000_000F);
    check("fresh_ovf", {63'd0, overflow_a}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
